// File: rtl/ring_scan_pkg.sv
// ring_scan_pkg: shared types and constants for the ring digit scanner.
// Holds the scanner FSM state enum, the active-high hex seven-segment
// table ({g,f,e,d,c,b,a}) and the all-segments-off pattern.
package ring_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'b0111111, // 0
        7'b0000110, // 1
        7'b1011011, // 2
        7'b1001111, // 3
        7'b1100110, // 4
        7'b1101101, // 5
        7'b1111101, // 6
        7'b0000111, // 7
        7'b1111111, // 8
        7'b1101111, // 9
        7'b1110111, // A
        7'b1111100, // b
        7'b0111001, // C
        7'b1011110, // d
        7'b1111001, // E
        7'b1110001  // F
    };

    // Active-high "nothing lit" pattern.
    localparam logic [6:0] SEG_ALL_OFF = 7'b0000000;

endpackage

// File: rtl/ring_digit_scanner_decode.sv
// seg7_hex_decode: combinational 4-bit hex to seven-segment decoder.
// Ports: nib_i (hex nibble), seg_o ({g,f,e,d,c,b,a}, polarity per ACTIVE_LOW).
module seg7_hex_decode
    import ring_scan_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    logic [6:0] seg_ah;

    assign seg_ah = SEG7_TABLE[nib_i];
    assign seg_o  = (ACTIVE_LOW != 0) ? ~seg_ah : seg_ah;

endmodule

// File: rtl/ring_digit_scanner.sv
// ring_digit_scanner: multiplexed seven-segment driver fed by a one-hot
// ring counter phase, with blanking on every phase change.
// Ports: clk, reset (sync, active-high), phase (one-hot digit select),
//   digits (packed nibbles), dp (per-digit point), an/seg/dp_out (registered
//   display pins), frame_done (one pulse per revolution), phase_err.
// Optional: define RING_SCAN_PHASE_CHECK_EN for a sticky illegal-phase flag;
//   otherwise phase_err is tied low.
module ring_digit_scanner
    import ring_scan_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int BLANK_CYCLES   = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_DIGITS-1:0]   phase,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic                  frame_done,
    output logic                  phase_err
);

    localparam int CNT_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam bit ACT_LOW = (SEG_ACTIVE_LOW != 0);

    localparam logic [CNT_W-1:0] CNT_RELOAD =
        (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
    localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{ACT_LOW}};
    localparam logic [6:0] SEG_OFF = ACT_LOW ? ~SEG_ALL_OFF : SEG_ALL_OFF;
    localparam logic DP_OFF = ACT_LOW;

    scan_state_e          state_q;
    logic [N_DIGITS-1:0]  phase_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [N_DIGITS-1:0]  an_q;
    logic [6:0]           seg_q;
    logic                 dp_q;
    logic                 fd_q;

    logic                 legal;
    logic                 change;
    logic                 is_last;
    logic [IDX_W-1:0]     idx;
    logic [3:0]           nib;
    logic [6:0]           dec_seg;
    logic [N_DIGITS-1:0]  an_ld;
    logic                 dp_ld;

    // One-hot test: nonzero and clearing the lowest set bit leaves nothing.
    assign legal   = (phase != '0) &&
                     ((phase & (phase - N_DIGITS'(1))) == '0);
    assign change  = (phase != phase_q);
    assign is_last = phase[N_DIGITS-1];

    always_comb begin
        idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (phase[i]) idx = IDX_W'(i);
        end
    end

    assign nib   = digits[4*idx +: 4];
    assign an_ld = ACT_LOW ? ~phase : phase;
    assign dp_ld = dp[idx] ^ ACT_LOW;

    seg7_hex_decode #(
        .ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_decode (
        .nib_i (nib),
        .seg_o (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            cnt_q   <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
            fd_q    <= 1'b0;
        end else begin
            phase_q <= phase;
            fd_q    <= 1'b0;
            if (!legal) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                an_q    <= AN_OFF;
                seg_q   <= SEG_OFF;
                dp_q    <= DP_OFF;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (BLANK_CYCLES > 0) begin
                            state_q <= BLANK;
                            cnt_q   <= CNT_RELOAD;
                            an_q    <= AN_OFF;
                            seg_q   <= SEG_OFF;
                            dp_q    <= DP_OFF;
                        end else begin
                            state_q <= DRIVE;
                            an_q    <= an_ld;
                            seg_q   <= dec_seg;
                            dp_q    <= dp_ld;
                            fd_q    <= is_last;
                        end
                    end
                    BLANK: begin
                        if (change) begin
                            cnt_q <= CNT_RELOAD;
                            an_q  <= AN_OFF;
                            seg_q <= SEG_OFF;
                            dp_q  <= DP_OFF;
                        end else if (cnt_q == '0) begin
                            state_q <= DRIVE;
                            an_q    <= an_ld;
                            seg_q   <= dec_seg;
                            dp_q    <= dp_ld;
                            fd_q    <= is_last;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                            an_q  <= AN_OFF;
                            seg_q <= SEG_OFF;
                            dp_q  <= DP_OFF;
                        end
                    end
                    DRIVE: begin
                        if (change) begin
                            if (BLANK_CYCLES > 0) begin
                                state_q <= BLANK;
                                cnt_q   <= CNT_RELOAD;
                                an_q    <= AN_OFF;
                                seg_q   <= SEG_OFF;
                                dp_q    <= DP_OFF;
                            end else begin
                                // No blanking: swap straight to new digit.
                                an_q  <= an_ld;
                                seg_q <= dec_seg;
                                dp_q  <= dp_ld;
                                fd_q  <= is_last;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        an_q    <= AN_OFF;
                        seg_q   <= SEG_OFF;
                        dp_q    <= DP_OFF;
                    end
                endcase
            end
        end
    end

`ifdef RING_SCAN_PHASE_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (!legal) begin
            err_q <= 1'b1;
        end
    end

    assign phase_err = err_q;
`else
    assign phase_err = 1'b0;
`endif

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp_out     = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_ring_digit_scanner.sv
// tb_ring_digit_scanner: directed, table-driven bench for ring_digit_scanner.
// Three instances cover BLANK_CYCLES = 1, 3 and 0 on shared stimulus.
module tb_ring_digit_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  phase;
    logic [15:0] digits;
    logic [3:0]  dp;

    logic [3:0] an1, an3, an0;
    logic [6:0] seg1, seg3, seg0;
    logic       dpo1, dpo3, dpo0;
    logic       fd1, fd3, fd0;
    logic       err1, err3, err0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

`ifdef RING_SCAN_PHASE_CHECK_EN
    localparam logic [31:0] ERR_EXP = 32'd1;
`else
    localparam logic [31:0] ERR_EXP = 32'd0;
`endif

    ring_digit_scanner #(
        .N_DIGITS(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .phase(phase), .digits(digits), .dp(dp),
        .an(an1), .seg(seg1), .dp_out(dpo1), .frame_done(fd1),
        .phase_err(err1)
    );

    ring_digit_scanner #(
        .N_DIGITS(4), .BLANK_CYCLES(3), .SEG_ACTIVE_LOW(1)
    ) u_dut3 (
        .clk(clk), .reset(reset), .phase(phase), .digits(digits), .dp(dp),
        .an(an3), .seg(seg3), .dp_out(dpo3), .frame_done(fd3),
        .phase_err(err3)
    );

    ring_digit_scanner #(
        .N_DIGITS(4), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1)
    ) u_dut0 (
        .clk(clk), .reset(reset), .phase(phase), .digits(digits), .dp(dp),
        .an(an0), .seg(seg0), .dp_out(dpo0), .frame_done(fd0),
        .phase_err(err0)
    );

    typedef struct {
        logic [3:0] ph;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } vec_t;

    vec_t rot[4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        logic [3:0] ph;
        logic [3:0] an_exp;
        int         fd_cnt;

        rot[0] = '{4'b0010, 4'b1101, 7'b0110000, 1'b1, 1'b0};
        rot[1] = '{4'b0100, 4'b1011, 7'b0001000, 1'b0, 1'b0};
        rot[2] = '{4'b1000, 4'b0111, 7'b0000000, 1'b1, 1'b1};
        rot[3] = '{4'b0001, 4'b1110, 7'b1000000, 1'b1, 1'b0};

        reset  = 1'b1;
        phase  = 4'b0001;
        digits = 16'h8A30;
        dp     = 4'b0100;

        // Reset state
        repeat (3) step();
        chk("rst_an", an1, 4'hF);
        chk("rst_seg", seg1, 7'h7F);
        chk("rst_dp", dpo1, 1'b1);
        chk("rst_fd", fd1, 1'b0);
        chk("rst_err", err1, 1'b0);

        reset = 1'b0;
        step();
        chk("rel_blank_an", an1, 4'hF);
        chk("rel_blank_fd", fd1, 1'b0);
        step();
        chk("rel_drive_an", an1, 4'b1110);
        chk("rel_drive_seg", seg1, 7'b1000000);
        chk("rel_drive_dp", dpo1, 1'b1);

        // Rotation through all digits, 10 cycles each
        fd_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            phase = rot[i].ph;
            step();
            fd_cnt += int'(fd1);
            chk("rot_blank_an", an1, 4'hF);
            chk("rot_blank_seg", seg1, 7'h7F);
            chk("rot_blank_fd", fd1, 1'b0);
            step();
            fd_cnt += int'(fd1);
            chk("rot_an", an1, rot[i].an);
            chk("rot_seg", seg1, rot[i].seg);
            chk("rot_dp", dpo1, rot[i].dp);
            chk("rot_fd", fd1, rot[i].fd);
            for (int h = 0; h < 8; h++) begin
                step();
                fd_cnt += int'(fd1);
                chk("rot_hold_an", an1, rot[i].an);
                chk("rot_hold_fd", fd1, 1'b0);
            end
        end
        chk("rot_fd_count", fd_cnt, 1);

        // Digit data is only sampled on entry to DRIVE
        digits = 16'h8A3F;
        step();
        chk("hold_seg", seg1, 7'b1000000);
        digits = 16'h8A30;

        // Illegal phase during DRIVE
        phase = 4'b0110;
        step();
        chk("ill_an", an1, 4'hF);
        chk("ill_seg", seg1, 7'h7F);
        chk("ill_dp", dpo1, 1'b1);
        chk("ill_err", err1, ERR_EXP);
        phase = 4'b0001;
        step();
        chk("ill_rec_blank", an1, 4'hF);
        chk("ill_rec_err", err1, ERR_EXP);
        step();
        chk("ill_rec_an", an1, 4'b1110);
        chk("ill_sticky_err", err1, ERR_EXP);

        // Reset while driving digit 2
        phase = 4'b0100;
        step();
        step();
        chk("mid_drive_an", an1, 4'b1011);
        reset = 1'b1;
        phase = 4'b1000;
        step();
        chk("mid_rst_an", an1, 4'hF);
        chk("mid_rst_seg", seg1, 7'h7F);
        chk("mid_rst_dp", dpo1, 1'b1);
        chk("mid_rst_fd", fd1, 1'b0);
        chk("mid_rst_err", err1, 1'b0);
        step();
        chk("mid_rst_fd2", fd1, 1'b0);

        // BLANK_CYCLES=3 latency and restart
        phase = 4'b0001;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("b3_start_blank", an3, 4'hF);
        end
        step();
        chk("b3_start_an", an3, 4'b1110);
        phase = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("b3_chg_blank", an3, 4'hF);
        end
        step();
        chk("b3_chg_an", an3, 4'b1101);
        chk("b3_chg_seg", seg3, 7'b0110000);
        phase = 4'b0100;
        step();
        chk("b3_k_blank", an3, 4'hF);
        phase = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("b3_restart_blank", an3, 4'hF);
            chk("b3_restart_fd", fd3, 1'b0);
        end
        step();
        chk("b3_restart_an", an3, 4'b0111);
        chk("b3_restart_seg", seg3, 7'b0000000);
        chk("b3_restart_fd_pulse", fd3, 1'b1);

        // BLANK_CYCLES=0, phase rotating every clock
        reset = 1'b1;
        phase = 4'b0001;
        step();
        reset = 1'b0;
        step();
        chk("b0_first_an", an0, 4'b1110);
        chk("b0_first_fd", fd0, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            ph     = 4'(1 << (c % 4));
            an_exp = ~ph;
            phase  = ph;
            step();
            chk("b0_rot_an", an0, an_exp);
            chk("b0_rot_fd", fd0, (c % 4) == 3);
        end
        phase = 4'b1000;
        step();
        chk("b0_last_fd", fd0, 1'b1);
        step();
        chk("b0_same_fd", fd0, 1'b0);
        chk("b0_same_an", an0, 4'b0111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
